// File: rtl/arp_pkg.sv
// Shared types and constants for the arpeggiated wavetable tone generator.
package arp_pkg;

    localparam int unsigned NUM_NOTES = 4;

    typedef logic [1:0] note_t;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PP   = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

    // Chord ratios in 1/256 units: root, major third, fifth, octave (divider shrinks as pitch rises).
    localparam logic [8:0] MULT [NUM_NOTES] = '{9'd256, 9'd203, 9'd171, 9'd128};

endpackage

// File: rtl/arp_wave_gen_if.sv
// Wavetable BRAM read port: registered address out, data back after the BRAM latency.
interface arp_wave_gen_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 11
);

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport master (output mem_addr, input mem_data);
    modport slave  (input mem_addr, output mem_data);

endinterface

// File: rtl/tone_divider.sv
// Free-running tone divider: advances the wavetable address every limit+1 clocks.
module tone_divider #(
    parameter int unsigned DIV_W  = 13,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  limit,
    output logic [ADDR_W-1:0] addr,
    output logic              adv
);

    logic [DIV_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              adv_q;

    // >= rather than == so a limit that drops below cnt still wraps promptly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            addr_q <= '0;
            adv_q  <= 1'b0;
        end else if (cnt_q >= limit) begin
            cnt_q  <= '0;
            addr_q <= addr_q + ADDR_W'(1);
            adv_q  <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + DIV_W'(1);
            adv_q  <= 1'b0;
        end
    end

    assign addr = addr_q;
    assign adv  = adv_q;

endmodule

// File: rtl/arp_wave_gen.sv
// Wavetable tone generator with a 4-note chord arpeggiator driving the divider limit.
module arp_wave_gen
    import arp_pkg::*;
#(
    parameter int unsigned DATA_W      = 11,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DIV_W       = 13,
    parameter int unsigned SW_W        = 8,
    parameter int unsigned BASE_DIV    = 746,
    parameter int unsigned STEP_CYCLES = 50000000,
    parameter int unsigned MEM_LAT     = 1
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic [SW_W-1:0]   sw,
    input  logic              arp_toggle,
    input  logic [1:0]        mode,
    arp_wave_gen_if.master    mem,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_strobe,
    output note_t             note,
    output logic              arp_en
);

    localparam int unsigned StepW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [StepW-1:0] StepLast = StepW'(STEP_CYCLES - 1);

    if (BASE_DIV + (2 ** SW_W) - 1 >= (2 ** DIV_W)) begin : g_base_chk
        $error("BASE_DIV + 2**SW_W - 1 does not fit in DIV_W bits");
    end

    logic [DIV_W-1:0]   base;
    logic [DIV_W+8:0]   prod;
    logic [DIV_W-1:0]   limit;
    logic [ADDR_W-1:0]  div_addr;
    logic               adv;

    logic               arp_en_q;
    note_t              note_q;
    dir_e               dir_q;
    logic [StepW-1:0]   step_q;
    logic [MEM_LAT:0]   strobe_sr_q;
    logic [DATA_W-1:0]  sample_q;

    assign base  = DIV_W'(BASE_DIV) + DIV_W'(sw);
    assign prod  = (DIV_W + 9)'(base) * (DIV_W + 9)'(MULT[note_q]);
    assign limit = DIV_W'(prod >> 8);

    tone_divider #(
        .DIV_W  (DIV_W),
        .ADDR_W (ADDR_W)
    ) u_div (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .limit (limit),
        .addr  (div_addr),
        .adv   (adv)
    );

    assign mem.mem_addr = div_addr;

    // A toggle takes priority over a coincident step tick, which is simply lost.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            arp_en_q <= 1'b0;
            note_q   <= '0;
            dir_q    <= DirUp;
            step_q   <= '0;
        end else if (arp_toggle) begin
            arp_en_q <= ~arp_en_q;
            step_q   <= '0;
            note_q   <= '0;
            if (!arp_en_q) dir_q <= DirUp;
        end else if (!arp_en_q) begin
            step_q <= '0;
            note_q <= '0;
        end else if (step_q != StepLast) begin
            step_q <= step_q + StepW'(1);
        end else begin
            step_q <= '0;
            unique case (mode_e'(mode))
                MODE_UP:   note_q <= note_q + 2'd1;
                MODE_DOWN: note_q <= note_q - 2'd1;
                MODE_PP: begin
                    if (note_q == 2'd3) begin
                        note_q <= 2'd2;
                        dir_q  <= DirDown;
                    end else if (note_q == 2'd0) begin
                        note_q <= 2'd1;
                        dir_q  <= DirUp;
                    end else begin
                        note_q <= (dir_q == DirUp) ? note_q + 2'd1 : note_q - 2'd1;
                    end
                end
                MODE_HOLD: note_q <= note_q;
            endcase
        end
    end

    // Strobe lines up with the BRAM latency plus the sample_out register.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            strobe_sr_q <= '0;
            sample_q    <= '0;
        end else begin
            strobe_sr_q <= (strobe_sr_q << 1) | (MEM_LAT + 1)'(adv);
            sample_q    <= mem.mem_data;
        end
    end

    assign sample_out    = sample_q;
    assign sample_strobe = strobe_sr_q[MEM_LAT];
    assign note          = note_q;
    assign arp_en        = arp_en_q;

endmodule

// File: tb/tb_arp_wave_gen.sv
// Self-checking bench for arp_wave_gen against a behavioural model of the chord generator.
module tb_arp_wave_gen;

    localparam int BASE  = 10;
    localparam int STEPS = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = '0;
    logic       arp_toggle = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [10:0] sample_out;
    logic        sample_strobe;
    logic [1:0]  note;
    logic        arp_en;

    arp_wave_gen_if #(.ADDR_W(8), .DATA_W(11)) mem_bus ();

    arp_wave_gen #(
        .DATA_W      (11),
        .ADDR_W      (8),
        .DIV_W       (13),
        .SW_W        (8),
        .BASE_DIV    (BASE),
        .STEP_CYCLES (STEPS),
        .MEM_LAT     (1)
    ) dut (
        .CLK100MHZ     (clk),
        .CPU_RESETN    (rst_n),
        .sw            (sw),
        .arp_toggle    (arp_toggle),
        .mode          (mode),
        .mem           (mem_bus),
        .sample_out    (sample_out),
        .sample_strobe (sample_strobe),
        .note          (note),
        .arp_en        (arp_en)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Behavioural model state
    int mult [4] = '{256, 203, 171, 128};
    int m_cnt, m_addr, m_step, m_note, m_dir;
    bit m_en;
    int h [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_addr = 0; m_step = 0; m_note = 0; m_dir = 0; m_en = 0;
        for (int i = 0; i < 4; i++) h[i] = 0;
    endtask

    // One clock: predict, clock the DUT, feed the 1-cycle BRAM model, compare.
    task automatic cycle();
        int lim, n_cnt, n_addr, n_step, n_note, n_dir;
        bit n_en;
        int a_before;
        lim = ((BASE + int'(sw)) * mult[m_note]) / 256;
        n_addr = m_addr;
        if (m_cnt >= lim) begin
            n_cnt = 0;
            n_addr = (m_addr + 1) % 256;
        end else begin
            n_cnt = m_cnt + 1;
        end
        n_en = m_en; n_step = m_step; n_note = m_note; n_dir = m_dir;
        if (arp_toggle) begin
            n_en = !m_en; n_step = 0; n_note = 0;
            if (!m_en) n_dir = 0;
        end else if (!m_en) begin
            n_step = 0; n_note = 0;
        end else if (m_step < STEPS - 1) begin
            n_step = m_step + 1;
        end else begin
            n_step = 0;
            case (mode)
                2'b00: n_note = (m_note + 1) % 4;
                2'b01: n_note = (m_note + 3) % 4;
                2'b10: begin
                    if (m_note == 3) begin n_note = 2; n_dir = 1; end
                    else if (m_note == 0) begin n_note = 1; n_dir = 0; end
                    else n_note = (m_dir == 1) ? m_note - 1 : m_note + 1;
                end
                default: n_note = m_note;
            endcase
        end
        a_before = int'(mem_bus.mem_addr);
        @(posedge clk);
        #1;
        mem_bus.mem_data = 11'(a_before * 3);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_cnt = n_cnt; m_addr = n_addr; m_en = n_en;
            m_step = n_step; m_note = n_note; m_dir = n_dir;
        end
        h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = m_addr;
        check("cyc_addr", mem_bus.mem_addr, m_addr);
        check("cyc_note", note, m_note);
        check("cyc_arp_en", arp_en, m_en);
        check("cyc_sample", sample_out, h[2] * 3);
        check("cyc_strobe", sample_strobe, (h[2] != h[3]) ? 1 : 0);
    endtask

    task automatic wait_addr_change(output int n);
        logic [7:0] prev;
        prev = mem_bus.mem_addr;
        n = 0;
        do begin
            cycle();
            n++;
        end while (mem_bus.mem_addr == prev && n < 1000);
    endtask

    task automatic wait_note_change(output int n);
        logic [1:0] prev;
        prev = note;
        n = 0;
        do begin
            cycle();
            n++;
        end while (note == prev && n < 200);
    endtask

    int n;
    int up_seq [4] = '{1, 2, 3, 0};
    int dn_seq [4] = '{3, 2, 1, 0};
    int pp_seq [7] = '{1, 2, 3, 2, 1, 0, 1};
    int per    [4] = '{201, 159, 134, 101};

    initial begin
        model_reset();
        mem_bus.mem_data = '0;

        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            sw = 8'($urandom);
            mode = 2'($urandom);
            arp_toggle = 1'($urandom);
            cycle();
        end
        check("rst_addr", mem_bus.mem_addr, 0);
        check("rst_arp_en", arp_en, 0);
        sw = 0; mode = 0; arp_toggle = 0;
        cycle();
        rst_n = 1'b1;

        // Base rate: advance every 11 clocks with wrap 255 -> 0
        for (int k = 1; k <= 258; k++) begin
            wait_addr_change(n);
            check("base_period", n, 11);
            check("base_addr", mem_bus.mem_addr, k % 256);
        end

        // UP
        arp_toggle = 1; cycle(); arp_toggle = 0;
        check("en_on", arp_en, 1);
        check("en_note", note, 0);
        for (int i = 0; i < 4; i++) begin
            wait_note_change(n);
            check("up_gap", n, STEPS);
            check("up_note", note, up_seq[i]);
        end
        // DOWN
        mode = 2'b01;
        for (int i = 0; i < 4; i++) begin
            wait_note_change(n);
            check("dn_gap", n, STEPS);
            check("dn_note", note, dn_seq[i]);
        end
        // PING-PONG
        mode = 2'b10;
        for (int i = 0; i < 7; i++) begin
            wait_note_change(n);
            check("pp_gap", n, STEPS);
            check("pp_note", note, pp_seq[i]);
        end
        // HOLD
        mode = 2'b11;
        for (int i = 0; i < 40; i++) cycle();
        check("hold_note", note, 1);

        // Toggle coincident with a tick at note 2
        mode = 2'b00;
        wait_note_change(n);
        check("tt_pre_note", note, 2);
        for (int i = 0; i < STEPS - 1; i++) cycle();
        arp_toggle = 1; cycle(); arp_toggle = 0;
        check("tt_arp_en", arp_en, 0);
        check("tt_note", note, 0);
        for (int i = 0; i < 20; i++) cycle();
        check("tt_note_held", note, 0);
        arp_toggle = 1; cycle(); arp_toggle = 0;
        wait_note_change(n);
        check("tt_re_gap", n, STEPS);
        check("tt_re_note", note, 1);

        // Randomized stretch, checked cycle by cycle against the model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) sw = 8'($urandom);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
            arp_toggle = ($urandom_range(0, 29) == 0);
            cycle();
        end
        arp_toggle = 0;

        // Per-note advance periods with base 200
        mode = 2'b00;
        if (m_en) begin
            arp_toggle = 1; cycle(); arp_toggle = 0;
        end
        sw = 8'd190;
        arp_toggle = 1; cycle(); arp_toggle = 0;
        mode = 2'b11;
        wait_addr_change(n);
        wait_addr_change(n);
        check("period_n0", n, per[0]);
        for (int k = 1; k < 4; k++) begin
            mode = 2'b00;
            wait_note_change(n);
            check("period_note", note, k);
            mode = 2'b11;
            wait_addr_change(n);
            wait_addr_change(n);
            check("period_nk", n, per[k]);
        end

        // Asynchronous reset mid-step at note 3
        for (int i = 0; i < 5; i++) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_addr", mem_bus.mem_addr, 0);
        check("arst_note", note, 0);
        check("arst_arp_en", arp_en, 0);
        check("arst_sample", sample_out, 0);
        check("arst_strobe", sample_strobe, 0);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            sw = 8'($urandom);
            mode = 2'($urandom);
            arp_toggle = 1'($urandom);
            cycle();
        end
        sw = 0; mode = 0; arp_toggle = 0;
        cycle();
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            wait_addr_change(n);
            check("rerun_period", n, 11);
            check("rerun_addr", mem_bus.mem_addr, k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
